mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 16-bit word RAM between two requesters: the UART command engine (host port, for memory read/write commands) and the MU0 core (cpu port).
- Host has priority. A bounded starvation counter guarantees CPU progress. A lock input gives the host exclusive ownership for whole-memory transfers.
- Sits between both requesters and the RAM macro; issues registered RAM commands and routes read data back to the requester that issued the read.

Parameters:
- ADDR_W, 16, address width of all ports
- DATA_W, 16, data word width
- MEM_WORDS, 32, number of implemented RAM words; addresses >= MEM_WORDS are out of range
- STARVE_LIMIT, 4, max consecutive host grants while cpu_req is pending (range 1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- host_req  in  1  host transfer request, held until accepted
- host_rnw  in  1  1=read, 0=write
- host_addr  in  ADDR_W  word address
- host_wdata  in  DATA_W  write data
- host_lock  in  1  host exclusive ownership request
- host_gnt  out  1  combinational accept; transfer happens on an edge with host_req&&host_gnt
- host_rvalid  out  1  read data valid pulse
- host_rdata  out  DATA_W  read data, 0 when host_rvalid=0
- cpu_req, cpu_rnw, cpu_addr, cpu_wdata  in  1/1/ADDR_W/DATA_W  same meaning as the host signals
- cpu_gnt, cpu_rvalid  out  1  same meaning as the host signals
- cpu_rdata  out  DATA_W  same meaning as host_rdata
- cpu_stall  out  1  cpu_req && !cpu_gnt (combinational)
- locked  out  1  registered; arbiter is in ARB_LOCK
- mem_en  out  1  registered RAM strobe
- mem_we  out  1  registered write enable, valid with mem_en
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a mem_en read
- addr_err  out  1  registered one-cycle pulse on an accepted out-of-range access

Behaviour:
- Reset (rst_n=0, asynchronous):
  - locked, mem_en, mem_we, addr_err, host_rvalid, cpu_rvalid = 0
  - mem_addr, mem_wdata = 0
  - state = ARB_IDLE, starve_cnt = 0
  - any in-flight read is dropped and produces no rvalid after reset.
- FSM states:
  - ARB_IDLE: last cycle had no grant.
  - ARB_HOST: last grant went to host.
  - ARB_CPU: last grant went to cpu.
  - ARB_LOCK: host exclusive.
- Grant rule in IDLE/HOST/CPU (combinational):
  - If host_req && !(cpu_req && starve_cnt==STARVE_LIMIT): host_gnt=1.
  - Else if cpu_req: cpu_gnt=1.
  - At most one gnt is high per cycle.
- starve_cnt:
  - Increments on each host acceptance while cpu_req=1.
  - Clears on cpu acceptance, or on any cycle with cpu_req=0.
  - Saturates at STARVE_LIMIT.
- Lock:
  - host_lock=1 sampled at an edge moves the FSM to ARB_LOCK; locked=1 from the next cycle.
  - In ARB_LOCK, cpu_gnt=0 and host_gnt=host_req.
  - Leaving: host_lock=0 at an edge returns the FSM to ARB_IDLE with starve_cnt cleared.
  - A CPU read accepted before lock still returns its cpu_rvalid normally.
- Latency:
  - Acceptance at edge N drives mem_* during cycle N+1.
  - A read gives rvalid=1 and rdata=mem_rdata on the issuing port in cycle N+2.
  - Back-to-back acceptances are allowed every cycle, giving full pipelining.
- Read routing: a registered tag {valid, port, err} follows each read into stage N+2.
- Out of range (addr >= MEM_WORDS):
  - The request is accepted and no mem_en is issued.
  - addr_err pulses in cycle N+1.
  - A write is dropped.
  - A read returns rvalid in N+2 with rdata=0.
- Address comparison: unsigned, full ADDR_W width.
- No grant: mem_en=0; mem_addr and mem_wdata hold their last values.
- Simultaneous host_lock rise and cpu_req in the same cycle: the grant for that cycle follows the non-lock rule; lock takes effect from the next cycle.

Decomposition:
- Shared package mu0_mem_pkg:
  - ARB_IDLE/ARB_HOST/ARB_CPU/ARB_LOCK state encodings (2-bit)
  - PORT_HOST=0, PORT_CPU=1 tag constants
  - default ADDR_W/DATA_W/MEM_WORDS
- Natural sub-module: mem_arb_rdtag, the 1-stage read-return tag pipeline and rdata/rvalid demux.

Test Plan:
- Reset mid-read: cpu read addr 5 accepted, rst_n low the next cycle -> no cpu_rvalid; all outputs 0.
- Host write addr 3 = 16'hBEEF, then host read addr 3 -> mem_en/mem_we=1 at N+1; host_rvalid with 16'hBEEF at N+2; cpu_rvalid stays 0.
- Both host_req and cpu_req held continuously, STARVE_LIMIT=4 -> grant sequence H,H,H,H,C,H,H,H,H,C; cpu_stall high on every host-grant cycle.
- host_lock=1 with cpu_req held for 10 cycles -> cpu_gnt=0 throughout and locked=1; after host_lock drops, cpu_gnt=1 within 1 cycle.
- Host read addr 32 (MEM_WORDS=32) -> no mem_en; addr_err pulses at N+1; host_rvalid with rdata 0 at N+2. Write to addr 16'hFFFF -> RAM unchanged.
- Alternating cpu read addr 1 and host read addr 2, back-to-back -> each rvalid lands on the correct port with that word's data, one per cycle.

Source files
------------

// File: rtl/mu0_mem_pkg.sv
// rtl/mu0_mem_pkg.sv - shared arbiter state encodings, port tags and default widths
package mu0_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOST = 2'd1,
    ARB_CPU  = 2'd2,
    ARB_LOCK = 2'd3
  } arbState_t;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_CPU  = 1'b1;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_WORDS = 32;

endpackage

// File: rtl/mem_arb_rdtag.sv
// rtl/mem_arb_rdtag.sv - read-return tag pipeline and rdata/rvalid demux
// A tag registered at acceptance becomes the rvalid strobe one cycle later, aligned with mem_rdata.
module mem_arb_rdtag
  import mu0_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issueValid,
  input  logic              issuePort,
  input  logic              issueErr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata
);

  logic tagValid;
  logic tagPort;
  logic tagErr;
  logic retErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagValid    <= 1'b0;
      tagPort     <= PORT_HOST;
      tagErr      <= 1'b0;
      retErr      <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
    end else begin
      tagValid    <= issueValid;
      tagPort     <= issuePort;
      tagErr      <= issueErr;
      retErr      <= tagErr;
      host_rvalid <= tagValid && (tagPort == PORT_HOST);
      cpu_rvalid  <= tagValid && (tagPort == PORT_CPU);
    end
  end

  // Out-of-range reads never touched the RAM, so they return zero.
  assign host_rdata = (host_rvalid && !retErr) ? mem_rdata : '0;
  assign cpu_rdata  = (cpu_rvalid && !retErr) ? mem_rdata : '0;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - host/cpu arbiter for the shared single-port word RAM
// Host-priority grant with bounded cpu starvation and a host exclusive lock.
module mem_arbiter
  import mu0_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_WORDS    = DEF_MEM_WORDS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_rnw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err
);

  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  arbState_t         state;
  logic [3:0]        starveCnt;
  logic              hostAcc;
  logic              cpuAcc;
  logic              anyAcc;
  logic              selRnw;
  logic              inRange;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  always_comb begin
    host_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    if (state == ARB_LOCK) begin
      host_gnt = host_req;
    end else if (host_req && !(cpu_req && starveCnt == STARVE_MAX)) begin
      host_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end
  end

  assign hostAcc   = host_req && host_gnt;
  assign cpuAcc    = cpu_req && cpu_gnt;
  assign anyAcc    = hostAcc || cpuAcc;
  assign selRnw    = cpuAcc ? cpu_rnw : host_rnw;
  assign selAddr   = cpuAcc ? cpu_addr : host_addr;
  assign selWdata  = cpuAcc ? cpu_wdata : host_wdata;
  assign inRange   = {1'b0, selAddr} < ADDR_LIMIT;
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      starveCnt <= '0;
      locked    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_err  <= 1'b0;
    end else begin
      mem_en   <= anyAcc && inRange;
      mem_we   <= anyAcc && inRange && !selRnw;
      addr_err <= anyAcc && !inRange;
      if (anyAcc && inRange) begin
        mem_addr  <= selAddr;
        mem_wdata <= selWdata;
      end
      if (!cpu_req || cpuAcc)
        starveCnt <= '0;
      else if (hostAcc && starveCnt < STARVE_MAX)
        starveCnt <= starveCnt + 4'd1;
      case (state)
        ARB_LOCK: begin
          if (!host_lock) begin
            state     <= ARB_IDLE;
            locked    <= 1'b0;
            starveCnt <= '0;
          end
        end
        default: begin
          if (host_lock) begin
            state  <= ARB_LOCK;
            locked <= 1'b1;
          end else if (hostAcc) begin
            state <= ARB_HOST;
          end else if (cpuAcc) begin
            state <= ARB_CPU;
          end else begin
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  mem_arb_rdtag #(.DATA_W(DATA_W)) u_rdtag (
    .clk        (clk),
    .rst_n      (rst_n),
    .issueValid (anyAcc && selRnw),
    .issuePort  (cpuAcc ? PORT_CPU : PORT_HOST),
    .issueErr   (!inRange),
    .mem_rdata  (mem_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a 32-word RAM model
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_rnw, host_lock;
  logic [15:0] host_addr, host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        cpu_req, cpu_rnw;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic [15:0] cpu_rdata;
  logic        locked, mem_en, mem_we, addr_err;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] ram [32];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(32), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .locked(locked), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  // RAM macro model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[4:0]];
    end
  end

  task automatic drive(input logic hr, input logic hrnw, input logic [15:0] ha, input logic [15:0] hw,
                       input logic cr, input logic crnw, input logic [15:0] ca, input logic [15:0] cw);
    host_req = hr; host_rnw = hrnw; host_addr = ha; host_wdata = hw;
    cpu_req = cr;  cpu_rnw = crnw;  cpu_addr = ca;  cpu_wdata = cw;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(0, 1, 0, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({locked, mem_en, mem_we, addr_err, host_rvalid, cpu_rvalid} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 000000", {locked, mem_en, mem_we, addr_err, host_rvalid, cpu_rvalid});
    end
    tests++;
    if ({mem_addr, mem_wdata, host_rdata, cpu_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_buses got %h exp 0", {mem_addr, mem_wdata, host_rdata, cpu_rdata});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    // cpu read of addr 5 accepted, then reset asserted before it returns
    @(posedge clk); #1; drive(0, 1, 0, 0, 1, 1, 16'd5, 0);
    @(negedge clk);
    tests++;
    if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL reset_mid_gnt got %b exp 1", cpu_gnt); end
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 1, 0, 0); rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin @(posedge clk); #1; rst_n = 1'b1; end
      @(negedge clk);
      tests++;
      if ({cpu_rvalid, host_rvalid, mem_en, addr_err, locked} !== 5'b0) begin
        fails++; $display("FAIL reset_mid_read i=%0d got %b exp 00000", i, {cpu_rvalid, host_rvalid, mem_en, addr_err, locked});
      end
      if (i >= 2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1; drive(1, 0, 16'd3, 16'hBEEF, 0, 1, 0, 0);
    @(negedge clk);
    tests++;
    if (host_gnt !== 1'b1) begin fails++; $display("FAIL wr_gnt got %b exp 1", host_gnt); end
    @(posedge clk); #1; drive(1, 1, 16'd3, 0, 0, 1, 0, 0);
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'd3, 16'hBEEF}) begin
      fails++; $display("FAIL wr_mem got %b%b %h %h exp 11 0003 beef", mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, host_rvalid} !== 3'b100) begin
      fails++; $display("FAIL rd_mem got %b exp 100", {mem_en, mem_we, host_rvalid});
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({host_rvalid, host_rdata, cpu_rvalid} !== {1'b1, 16'hBEEF, 1'b0}) begin
      fails++; $display("FAIL rd_data got %b %h %b exp 1 beef 0", host_rvalid, host_rdata, cpu_rvalid);
    end
    idle_cycles(2);
  endtask

  task automatic test_starvation();
    @(posedge clk); #1; drive(1, 1, 16'd2, 0, 1, 1, 16'd1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({host_gnt, cpu_gnt, cpu_stall} !== ((i % 5 == 4) ? 3'b010 : 3'b101)) begin
        fails++; $display("FAIL starve i=%0d got %b exp %b", i, {host_gnt, cpu_gnt, cpu_stall}, (i % 5 == 4) ? 3'b010 : 3'b101);
      end
      @(posedge clk); #1;
    end
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    idle_cycles(3);
  endtask

  task automatic test_lock();
    @(posedge clk); #1; drive(0, 1, 0, 0, 1, 1, 16'd3, 0); host_lock = 1'b1;
    @(negedge clk);
    tests++;
    if ({cpu_gnt, locked} !== 2'b10) begin fails++; $display("FAIL lock_first got %b exp 10", {cpu_gnt, locked}); end
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if ({cpu_gnt, locked, cpu_rvalid, cpu_rdata} !== {2'b01, (j == 1), (j == 1) ? 16'hBEEF : 16'h0}) begin
        fails++; $display("FAIL lock_hold j=%0d got %b%b %b %h", j, cpu_gnt, locked, cpu_rvalid, cpu_rdata);
      end
    end
    @(posedge clk); #1; host_lock = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({cpu_gnt, locked} !== 2'b10) begin fails++; $display("FAIL lock_release got %b exp 10", {cpu_gnt, locked}); end
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 1, 0, 0);
    idle_cycles(3);
  endtask

  task automatic test_out_of_range();
    logic [15:0] snap [32];
    bit same;
    for (int i = 0; i < 32; i++) snap[i] = ram[i];
    @(posedge clk); #1; drive(1, 1, 16'd32, 0, 0, 1, 0, 0);
    @(posedge clk); #1; drive(1, 0, 16'hFFFF, 16'h5A5A, 0, 1, 0, 0);
    @(negedge clk);
    tests++;
    if ({mem_en, addr_err, host_rvalid} !== 3'b010) begin
      fails++; $display("FAIL oor_rd_err got %b exp 010", {mem_en, addr_err, host_rvalid});
    end
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    tests++;
    if ({mem_en, addr_err, host_rvalid, host_rdata} !== {3'b011, 16'h0}) begin
      fails++; $display("FAIL oor_rd_ret got %b%b%b %h exp 011 0000", mem_en, addr_err, host_rvalid, host_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({mem_en, addr_err, host_rvalid} !== 3'b000) begin
      fails++; $display("FAIL oor_wr_tail got %b exp 000", {mem_en, addr_err, host_rvalid});
    end
    idle_cycles(2);
    same = 1;
    for (int i = 0; i < 32; i++) if (ram[i] !== snap[i]) same = 0;
    tests++;
    if (!same) begin fails++; $display("FAIL oor_ram_changed got changed exp unchanged"); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1; drive(1, 0, 16'd1, 16'h1111, 0, 1, 0, 0);
    @(posedge clk); #1; drive(1, 0, 16'd2, 16'h2222, 0, 1, 0, 0);
    idle_cycles(2);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (j >= 8)          drive(0, 1, 0, 0, 0, 1, 0, 0);
      else if (j % 2 == 0) drive(0, 1, 0, 0, 1, 1, 16'd1, 0);
      else                 drive(1, 1, 16'd2, 0, 0, 1, 0, 0);
      @(negedge clk);
      if (j < 8) begin
        tests++;
        if ({host_gnt, cpu_gnt} !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
          fails++; $display("FAIL b2b_gnt j=%0d got %b", j, {host_gnt, cpu_gnt});
        end
      end
      if (j >= 2) begin
        tests++;
        if ({host_rvalid, host_rdata, cpu_rvalid, cpu_rdata} !==
            ((j % 2 == 0) ? {1'b0, 16'h0, 1'b1, 16'h1111} : {1'b1, 16'h2222, 1'b0, 16'h0})) begin
          fails++; $display("FAIL b2b_ret j=%0d got h%b %h c%b %h", j, host_rvalid, host_rdata, cpu_rvalid, cpu_rdata);
        end
      end
    end
    idle_cycles(2);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'(32 + $urandom_range(0, 7));
      1:       return 16'hFFFF;
      default: return 16'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    logic [15:0] expMem [32];
    bit          expHV [4], expCV [4], expErr [4], expEn [4];
    logic [15:0] expHD [4], expCD [4];
    bit          mLock, hacc, cacc, eh, ec, inr, rnw;
    int          mStarve, lockLeft, s;
    logic [15:0] a, d;
    mLock = 0; mStarve = 0; lockLeft = 0;
    for (int i = 0; i < 32; i++) expMem[i] = ram[i];
    for (int i = 0; i < 4; i++) begin
      expHV[i] = 0; expCV[i] = 0; expErr[i] = 0; expEn[i] = 0; expHD[i] = 0; expCD[i] = 0;
    end
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3) != 0, 1'($urandom), rand_addr(), 16'($urandom),
            1'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
      if (lockLeft > 0) lockLeft--;
      else if ($urandom_range(0, 29) == 0) lockLeft = $urandom_range(2, 8);
      host_lock = (lockLeft > 0);
      @(negedge clk);
      eh = mLock ? host_req : (host_req && !(cpu_req && mStarve == STARVE));
      ec = !mLock && cpu_req && !eh;
      s = k % 4;
      tests++;
      if ({host_gnt, cpu_gnt, cpu_stall, locked, addr_err, mem_en} !==
          {eh, ec, cpu_req && !ec, mLock, expErr[s], expEn[s]}) begin
        fails++; $display("FAIL rnd_ctrl k=%0d got %b exp %b", k, {host_gnt, cpu_gnt, cpu_stall, locked, addr_err, mem_en},
                          {eh, ec, cpu_req && !ec, mLock, expErr[s], expEn[s]});
      end
      tests++;
      if ({host_rvalid, host_rdata, cpu_rvalid, cpu_rdata} !== {expHV[s], expHD[s], expCV[s], expCD[s]}) begin
        fails++; $display("FAIL rnd_ret k=%0d got h%b %h c%b %h exp h%b %h c%b %h", k, host_rvalid, host_rdata,
                          cpu_rvalid, cpu_rdata, expHV[s], expHD[s], expCV[s], expCD[s]);
      end
      expHV[s] = 0; expCV[s] = 0; expErr[s] = 0; expEn[s] = 0; expHD[s] = 0; expCD[s] = 0;
      hacc = host_req && eh;
      cacc = cpu_req && ec;
      if (hacc || cacc) begin
        a   = cacc ? cpu_addr : host_addr;
        d   = cacc ? cpu_wdata : host_wdata;
        rnw = cacc ? cpu_rnw : host_rnw;
        inr = (a < 16'd32);
        expErr[(k + 1) % 4] = !inr;
        expEn[(k + 1) % 4]  = inr;
        if (rnw) begin
          if (cacc) begin expCV[(k + 2) % 4] = 1; expCD[(k + 2) % 4] = inr ? expMem[a[4:0]] : 16'h0; end
          else      begin expHV[(k + 2) % 4] = 1; expHD[(k + 2) % 4] = inr ? expMem[a[4:0]] : 16'h0; end
        end else if (inr) begin
          expMem[a[4:0]] = d;
        end
      end
      if (!cpu_req || cacc) mStarve = 0;
      else if (hacc && mStarve < STARVE) mStarve++;
      if (mLock) begin
        if (!host_lock) begin mLock = 0; mStarve = 0; end
      end else if (host_lock) begin
        mLock = 1;
      end
    end
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 1, 0, 0); host_lock = 1'b0;
    idle_cycles(3);
  endtask

  initial begin
    rst_n = 1'b0;
    host_lock = 1'b0;
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    test_reset();
    test_write_read();
    test_starvation();
    test_lock();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
